// File: rtl/jtag_dr_pkg.sv
// jtag_dr_pkg: shared constants and helpers for the JTAG data register bank
package jtag_dr_pkg;
  localparam int BYPASS_LEN = 1;
  function automatic logic sel_is_bypass(input int unsigned sel, input int unsigned num_chains);
    return sel >= num_chains;
  endfunction
  function automatic int unsigned slice_lo(input int unsigned k, input int unsigned width);
    return k * width;
  endfunction
endpackage

// File: rtl/jtag_dr_chain.sv
// jtag_dr_chain: one capture/shift/update data register cell
module jtag_dr_chain #(
  parameter int DR_WIDTH = 64,
  parameter bit UPD_RST = 1'b0
) (
  input  logic                tclk,
  input  logic                trst_n,
  input  logic                tdi,
  input  logic                cap,
  input  logic                shf,
  input  logic                upd,
  input  logic [DR_WIDTH-1:0] pin,
  output logic                lsb,
  output logic [DR_WIDTH-1:0] upd_q
);
  logic [DR_WIDTH-1:0] sr;
  // shift stage: capture has priority over shift, LSB leaves first
  always_ff @(posedge tclk or negedge trst_n)
    if (!trst_n) sr <= '0;
    else if (cap) sr <= pin;
    else if (shf) sr <= {tdi, sr[DR_WIDTH-1:1]};
  // update stage samples the pre-edge shift contents
  always_ff @(posedge tclk or negedge trst_n)
    if (!trst_n) upd_q <= {DR_WIDTH{UPD_RST}};
    else if (upd) upd_q <= sr;
  assign lsb = sr[0];
endmodule

// File: rtl/jtag_dr_bank.sv
// jtag_dr_bank: bank of JTAG data chains plus bypass, select latch, shift monitor and retimed tdo
module jtag_dr_bank
  import jtag_dr_pkg::*;
#(
  parameter int DR_WIDTH = 64,
  parameter int NUM_CHAINS = 4,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16,
  parameter bit UPD_RST = 1'b0
) (
  input  logic                           tclk,
  input  logic                           trst_n,
  input  logic                           tdi,
  input  logic                           capture_en,
  input  logic                           shift_en,
  input  logic                           update_en,
  input  logic [SEL_W-1:0]               chain_sel,
  input  logic [NUM_CHAINS*DR_WIDTH-1:0] parallel_inputs,
  output logic                           tdo,
  output logic [NUM_CHAINS*DR_WIDTH-1:0] update_regs,
  output logic [SEL_W-1:0]               active_sel,
  output logic [CNT_W-1:0]               shift_count,
  output logic                           shift_overflow
);
  localparam logic [CNT_W-1:0] LEN_DR = CNT_W'(DR_WIDTH);
  localparam logic [CNT_W-1:0] LEN_BYP = CNT_W'(BYPASS_LEN);
  logic [NUM_CHAINS-1:0] lsbs;
  logic byp, byp_act, cap_byp, shf, cur;
  logic [CNT_W-1:0] len;
  assign byp_act = sel_is_bypass(32'(active_sel), NUM_CHAINS);
  assign cap_byp = sel_is_bypass(32'(chain_sel), NUM_CHAINS);
  assign shf = !capture_en && shift_en;
  assign len = byp_act ? LEN_BYP : LEN_DR;
  genvar k;
  generate
    for (k = 0; k < NUM_CHAINS; k++) begin : g_chain
      localparam int LO = slice_lo(k, DR_WIDTH);
      jtag_dr_chain #(.DR_WIDTH(DR_WIDTH), .UPD_RST(UPD_RST)) u_chain (
        .tclk  (tclk),
        .trst_n(trst_n),
        .tdi   (tdi),
        .cap   (capture_en && chain_sel == SEL_W'(k)),
        .shf   (shf && active_sel == SEL_W'(k)),
        .upd   (update_en && active_sel == SEL_W'(k)),
        .pin   (parallel_inputs[LO +: DR_WIDTH]),
        .lsb   (lsbs[k]),
        .upd_q (update_regs[LO +: DR_WIDTH])
      );
    end
  endgenerate
  // select latch, bypass bit and saturating shift-length monitor
  always_ff @(posedge tclk or negedge trst_n)
    if (!trst_n) begin
      active_sel <= '0;
      byp <= 1'b0;
      shift_count <= '0;
      shift_overflow <= 1'b0;
    end else if (capture_en) begin
      active_sel <= chain_sel;
      byp <= cap_byp ? 1'b0 : byp;
      shift_count <= '0;
      shift_overflow <= 1'b0;
    end else if (shift_en) begin
      byp <= byp_act ? tdi : byp;
      shift_count <= (&shift_count) ? shift_count : shift_count + 1'b1;
      shift_overflow <= shift_overflow || (shift_count >= len);
    end
  // LSB of the active chain, bypass bit when no data chain matches
  always_comb begin
    cur = byp;
    for (int i = 0; i < NUM_CHAINS; i++) if (active_sel == SEL_W'(i)) cur = lsbs[i];
  end
  // tdo retimed on the falling edge
  always_ff @(negedge tclk or negedge trst_n)
    if (!trst_n) tdo <= 1'b0;
    else tdo <= cur;
endmodule
